genius_turn_timer_ctrl: RTL and testbench
=========================================

// Module: genius_turn_timer_ctrl
// PURPOSE
//  Sequences the per-turn seconds timer of the Genius game.
//  Holds the timer during SHOW (sequence playback), runs it during PLAY (player input),
//  restarts it on every accepted key, and raises a timeout when the player stalls.
//  Sits between the game FSM and the display: game FSM drives start/show_done/key/round_done,
//  and this block returns phase, elapsed seconds and timeout.
// PARAMETERS
//  LIMIT  10  seconds allowed per key press; legal 2..15; timeout on the tick that would reach LIMIT
// PORTS
//  CLK1          in   1  system clock (one clock domain); all logic on posedge CLK1
//  R_N           in   1  reset, asynchronous, active-low
//  tick_i        in   1  1 Hz enable pulse, one CLK1 cycle wide
//  start_i       in   1  pulse: new game (accepted in IDLE and EXPIRED)
//  show_done_i   in   1  pulse: sequence playback finished
//  key_valid_i   in   1  pulse: correct key accepted; restarts the window
//  round_done_i  in   1  pulse: player completed the round
//  abort_i       in   1  pulse: synchronous return to IDLE from any state
//  phase_o       out  2  00 IDLE, 01 SHOW, 10 PLAY, 11 EXPIRED
//  tempo_o       out  4  elapsed seconds in current window, 0..LIMIT-1
//  secs_left_o   out  4  LIMIT - tempo_o in PLAY, else 0
//  timeout_o     out  1  one-cycle pulse on entry to EXPIRED
//  fail_o        out  1  level, high while in EXPIRED
// BEHAVIOUR
//  - Reset (R_N=0, async): state IDLE, tempo_o=0, secs_left_o=0, timeout_o=0, fail_o=0.
//  - All outputs are registered; each output reflects the state/counter one cycle after the causing input.
//  - IDLE: counter held at 0. start_i -> SHOW.
//  - SHOW: counter held at 0, tick_i ignored. show_done_i -> PLAY with tempo 0.
//  - PLAY, evaluated per cycle in this priority order:
//    1 abort_i -> IDLE;
//    2 round_done_i -> SHOW, tempo 0;
//    3 key_valid_i -> stay in PLAY, tempo 0 (a tick_i in the same cycle is discarded);
//    4 tick_i with tempo==LIMIT-1 -> EXPIRED, tempo wraps to 0, timeout_o=1 for one cycle;
//    5 tick_i otherwise -> tempo+1.
//  - EXPIRED: tempo held at 0, fail_o=1. start_i -> SHOW (new game). abort_i -> IDLE.
//  - abort_i has top priority in every state. start_i outside IDLE/EXPIRED is ignored.
//  - show_done_i outside SHOW, and key_valid_i/round_done_i outside PLAY, are ignored.
//  - Unsigned 4-bit arithmetic. tempo never exceeds LIMIT-1, so secs_left_o ranges 1..LIMIT in PLAY.
//  - Timeout occurs exactly LIMIT ticks after PLAY entry or after the last key_valid_i.
//  - Reset asserted mid-PLAY: immediate return to IDLE/0; no timeout pulse is generated.
//  - Unused phase encodings are impossible; treat any illegal state as IDLE (default branch).
// STRUCTURE
//  - Shared package/header genius_pkg: phase encodings PH_IDLE/PH_SHOW/PH_PLAY/PH_EXP (2-bit localparams),
//    and the default LIMIT.
//  - One sub-module: genius_sec_counter.
//    Ports: CLK1, R_N, clr, en, max[3:0], count[3:0], wrap.
//    Behaviour: when en && count==max, count wraps to 0 and wrap pulses. clr takes priority over en.
//  - Parent contains the 4-state FSM, the priority logic, and the output registers.
// TESTING
//  1 Reset then start_i, show_done_i, 10 ticks (LIMIT=10) -> tempo 0..9;
//    10th tick: phase 11, timeout_o pulses once, fail_o=1.
//  2 In PLAY at tempo=7, key_valid_i -> tempo=0 next cycle;
//    a further 10 ticks are needed to time out.
//  3 key_valid_i and tick_i in the same cycle at tempo=9 -> tempo=0, phase stays 10, no timeout.
//  4 round_done_i and tick_i in the same cycle at tempo=9 -> phase 01, tempo 0, no timeout;
//    ticks in SHOW leave tempo at 0.
//  5 R_N low mid-PLAY at tempo=5 -> all outputs 0 asynchronously;
//    start_i in EXPIRED -> phase 01, fail_o=0.
//  6 abort_i in each of the 4 states -> phase 00 next cycle;
//    start_i while in PLAY -> ignored.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius turn timer: phase encodings and default turn limit.
package genius_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'b00,
        PH_SHOW = 2'b01,
        PH_PLAY = 2'b10,
        PH_EXP  = 2'b11
    } phase_e;

    localparam int unsigned LIMIT_DEF = 10;

endpackage

// File: rtl/genius_sec_counter.sv
// Seconds counter: clears on clr, advances on en, wraps to 0 after max with a one-cycle wrap flag.
module genius_sec_counter (
    input  logic       CLK1,
    input  logic       R_N,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] max,
    output logic [3:0] count,
    output logic       wrap
);

    logic [3:0] count_q;

    always_ff @(posedge CLK1 or negedge R_N) begin
        if (!R_N) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= (count_q == max) ? '0 : count_q + 4'd1;
        end
    end

    assign count = count_q;
    assign wrap  = en && !clr && (count_q == max);

endmodule

// File: rtl/genius_turn_timer_ctrl.sv
// Per-turn timer sequencer: holds during SHOW, runs during PLAY, restarts on keys, flags timeouts.
module genius_turn_timer_ctrl
    import genius_pkg::*;
#(
    parameter int unsigned LIMIT = LIMIT_DEF
) (
    input  logic       CLK1,
    input  logic       R_N,
    input  logic       tick_i,
    input  logic       start_i,
    input  logic       show_done_i,
    input  logic       key_valid_i,
    input  logic       round_done_i,
    input  logic       abort_i,
    output logic [1:0] phase_o,
    output logic [3:0] tempo_o,
    output logic [3:0] secs_left_o,
    output logic       timeout_o,
    output logic       fail_o
);

    localparam logic [3:0] LIM4 = 4'(LIMIT);
    localparam logic [3:0] MAX4 = 4'(LIMIT - 1);

    phase_e     state_q, state_d;
    logic [3:0] secs_q, secs_d;
    logic       timeout_q, timeout_d;
    logic       fail_q, fail_d;

    logic       in_play;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_wrap;
    logic [3:0] cnt_val;

    // Any higher-priority PLAY event, or being outside PLAY, zeroes the window.
    assign in_play = (state_q == PH_PLAY);
    assign cnt_clr = !in_play || abort_i || round_done_i || key_valid_i;
    assign cnt_en  = in_play && tick_i;

    genius_sec_counter u_sec (
        .CLK1  (CLK1),
        .R_N   (R_N),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .max   (MAX4),
        .count (cnt_val),
        .wrap  (cnt_wrap)
    );

    always_comb begin
        state_d   = state_q;
        secs_d    = secs_q;
        timeout_d = 1'b0;
        case (state_q)
            PH_IDLE: begin
                secs_d = '0;
                if (!abort_i && start_i) begin
                    state_d = PH_SHOW;
                end
            end
            PH_SHOW: begin
                if (abort_i) begin
                    state_d = PH_IDLE;
                end else if (show_done_i) begin
                    state_d = PH_PLAY;
                    secs_d  = LIM4;
                end
            end
            PH_PLAY: begin
                if (abort_i) begin
                    state_d = PH_IDLE;
                    secs_d  = '0;
                end else if (round_done_i) begin
                    state_d = PH_SHOW;
                    secs_d  = '0;
                end else if (key_valid_i) begin
                    secs_d = LIM4;
                end else if (cnt_wrap) begin
                    state_d   = PH_EXP;
                    secs_d    = '0;
                    timeout_d = 1'b1;
                end else if (tick_i) begin
                    // secs_left tracks LIMIT - tempo as a down-counter alongside the seconds counter.
                    secs_d = secs_q - 4'd1;
                end
            end
            PH_EXP: begin
                if (abort_i) begin
                    state_d = PH_IDLE;
                end else if (start_i) begin
                    state_d = PH_SHOW;
                end
            end
            default: begin
                state_d = PH_IDLE;
                secs_d  = '0;
            end
        endcase
        fail_d = (state_d == PH_EXP);
    end

    always_ff @(posedge CLK1 or negedge R_N) begin
        if (!R_N) begin
            state_q   <= PH_IDLE;
            secs_q    <= '0;
            timeout_q <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            secs_q    <= secs_d;
            timeout_q <= timeout_d;
            fail_q    <= fail_d;
        end
    end

    assign phase_o     = state_q;
    assign tempo_o     = cnt_val;
    assign secs_left_o = secs_q;
    assign timeout_o   = timeout_q;
    assign fail_o      = fail_q;

endmodule

// File: tb/tb_genius_turn_timer_ctrl.sv
// Self-checking bench for genius_turn_timer_ctrl: directed vector table, corner sequences, random vs model.
module tb_genius_turn_timer_ctrl;

    localparam int unsigned LIMIT = 10;

    // input bit order: {start, show_done, key_valid, round_done, abort, tick}
    localparam logic [5:0] NO = 6'b000000;
    localparam logic [5:0] TK = 6'b000001;
    localparam logic [5:0] AB = 6'b000010;
    localparam logic [5:0] RD = 6'b000100;
    localparam logic [5:0] KV = 6'b001000;
    localparam logic [5:0] SD = 6'b010000;
    localparam logic [5:0] ST = 6'b100000;

    typedef struct {
        logic [5:0] in;
        logic [1:0] ph;
        logic [3:0] tempo;
        logic [3:0] secs;
        logic       to;
        logic       fl;
    } vec_t;

    logic       CLK1;
    logic       R_N;
    logic       tick_i, start_i, show_done_i, key_valid_i, round_done_i, abort_i;
    logic [1:0] phase_o;
    logic [3:0] tempo_o;
    logic [3:0] secs_left_o;
    logic       timeout_o;
    logic       fail_o;

    int total;
    int bad;

    int m_ph;
    int m_el;
    bit m_to;

    vec_t tq[$];

    genius_turn_timer_ctrl #(.LIMIT(LIMIT)) dut (
        .CLK1         (CLK1),
        .R_N          (R_N),
        .tick_i       (tick_i),
        .start_i      (start_i),
        .show_done_i  (show_done_i),
        .key_valid_i  (key_valid_i),
        .round_done_i (round_done_i),
        .abort_i      (abort_i),
        .phase_o      (phase_o),
        .tempo_o      (tempo_o),
        .secs_left_o  (secs_left_o),
        .timeout_o    (timeout_o),
        .fail_o       (fail_o)
    );

    initial CLK1 = 1'b0;
    always #5 CLK1 = ~CLK1;

    function automatic vec_t v(input logic [5:0] in, input logic [1:0] ph,
                               input int t, input int s, input logic to, input logic fl);
        vec_t r;
        r.in = in; r.ph = ph; r.tempo = 4'(t); r.secs = 4'(s); r.to = to; r.fl = fl;
        return r;
    endfunction

    task automatic check_exp(input string nm, input logic [1:0] ph, input logic [3:0] t,
                             input logic [3:0] s, input logic to, input logic fl);
        total++;
        if (phase_o !== ph || tempo_o !== t || secs_left_o !== s || timeout_o !== to || fail_o !== fl) begin
            bad++;
            $display("FAIL %s: got ph=%b tempo=%0d secs=%0d to=%b fail=%b, want ph=%b tempo=%0d secs=%0d to=%b fail=%b",
                     nm, phase_o, tempo_o, secs_left_o, timeout_o, fail_o, ph, t, s, to, fl);
        end
    endtask

    // Reference: phase number plus elapsed seconds in the current window.
    task automatic model_step(input logic [5:0] in);
        bit st, sd, kv, rd, ab, tk;
        {st, sd, kv, rd, ab, tk} = in;
        m_to = 0;
        if (ab) begin
            m_ph = 0; m_el = 0;
        end else begin
            case (m_ph)
                0: if (st) m_ph = 1;
                1: if (sd) begin m_ph = 2; m_el = 0; end
                2: begin
                    if (rd) begin m_ph = 1; m_el = 0; end
                    else if (kv) m_el = 0;
                    else if (tk) begin
                        if (m_el + 1 >= int'(LIMIT)) begin m_ph = 3; m_el = 0; m_to = 1; end
                        else m_el = m_el + 1;
                    end
                end
                default: if (st) m_ph = 1;
            endcase
        end
    endtask

    task automatic check_model(input string nm);
        check_exp(nm, 2'(m_ph), 4'(m_el), (m_ph == 2) ? 4'(int'(LIMIT) - m_el) : 4'd0,
                  m_to, m_ph == 3);
    endtask

    task automatic apply(input logic [5:0] in);
        {start_i, show_done_i, key_valid_i, round_done_i, abort_i, tick_i} = in;
        @(posedge CLK1);
        #1;
        model_step(in);
        {start_i, show_done_i, key_valid_i, round_done_i, abort_i, tick_i} = '0;
    endtask

    task automatic do_reset(input string nm);
        R_N = 1'b0;
        #2;
        check_exp(nm, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge CLK1);
        #1;
        R_N = 1'b1;
        m_ph = 0; m_el = 0; m_to = 0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        R_N   = 1'b0;
        {start_i, show_done_i, key_valid_i, round_done_i, abort_i, tick_i} = '0;
        m_ph = 0; m_el = 0; m_to = 0;

        // directed table: full timeout, key+tick collision, round+tick collision, ignores, aborts
        tq.push_back(v(TK, 2'd0, 0, 0, 0, 0));
        tq.push_back(v(ST, 2'd1, 0, 0, 0, 0));
        tq.push_back(v(TK, 2'd1, 0, 0, 0, 0));
        tq.push_back(v(KV, 2'd1, 0, 0, 0, 0));
        tq.push_back(v(SD, 2'd2, 0, 10, 0, 0));
        for (int i = 1; i <= 9; i++) tq.push_back(v(TK, 2'd2, i, 10 - i, 0, 0));
        tq.push_back(v(TK, 2'd3, 0, 0, 1, 1));
        tq.push_back(v(NO, 2'd3, 0, 0, 0, 1));
        tq.push_back(v(TK, 2'd3, 0, 0, 0, 1));
        tq.push_back(v(SD, 2'd3, 0, 0, 0, 1));
        tq.push_back(v(ST, 2'd1, 0, 0, 0, 0));
        tq.push_back(v(SD, 2'd2, 0, 10, 0, 0));
        for (int i = 1; i <= 9; i++) tq.push_back(v(TK, 2'd2, i, 10 - i, 0, 0));
        tq.push_back(v(KV | TK, 2'd2, 0, 10, 0, 0));
        for (int i = 1; i <= 9; i++) tq.push_back(v(TK, 2'd2, i, 10 - i, 0, 0));
        tq.push_back(v(RD | TK, 2'd1, 0, 0, 0, 0));
        tq.push_back(v(TK, 2'd1, 0, 0, 0, 0));
        tq.push_back(v(ST, 2'd1, 0, 0, 0, 0));
        tq.push_back(v(SD, 2'd2, 0, 10, 0, 0));
        tq.push_back(v(ST, 2'd2, 0, 10, 0, 0));
        tq.push_back(v(TK, 2'd2, 1, 9, 0, 0));
        tq.push_back(v(AB, 2'd0, 0, 0, 0, 0));
        tq.push_back(v(AB, 2'd0, 0, 0, 0, 0));
        tq.push_back(v(ST | AB, 2'd0, 0, 0, 0, 0));
        tq.push_back(v(ST, 2'd1, 0, 0, 0, 0));
        tq.push_back(v(AB, 2'd0, 0, 0, 0, 0));
        tq.push_back(v(ST, 2'd1, 0, 0, 0, 0));
        tq.push_back(v(SD, 2'd2, 0, 10, 0, 0));
        for (int i = 1; i <= 9; i++) tq.push_back(v(TK, 2'd2, i, 10 - i, 0, 0));
        tq.push_back(v(TK, 2'd3, 0, 0, 1, 1));
        tq.push_back(v(AB, 2'd0, 0, 0, 0, 0));

        #3;
        check_exp("reset_state", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge CLK1);
        #1;
        R_N = 1'b1;

        for (int i = 0; i < tq.size(); i++) begin
            apply(tq[i].in);
            check_exp($sformatf("vec%0d", i), tq[i].ph, tq[i].tempo, tq[i].secs, tq[i].to, tq[i].fl);
        end

        // key at tempo 7 restarts the window; a further LIMIT ticks are needed
        do_reset("rst_key");
        apply(ST);
        apply(SD);
        for (int i = 0; i < 7; i++) apply(TK);
        check_exp("key_pre_t7", 2'b10, 4'd7, 4'd3, 1'b0, 1'b0);
        apply(KV);
        check_exp("key_clr", 2'b10, 4'd0, 4'd10, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) apply(TK);
        check_exp("key_9ticks", 2'b10, 4'd9, 4'd1, 1'b0, 1'b0);
        apply(TK);
        check_exp("key_timeout", 2'b11, 4'd0, 4'd0, 1'b1, 1'b1);

        // asynchronous reset mid-PLAY at tempo 5
        do_reset("rst_async_pre");
        apply(ST);
        apply(SD);
        for (int i = 0; i < 5; i++) apply(TK);
        check_exp("async_pre_t5", 2'b10, 4'd5, 4'd5, 1'b0, 1'b0);
        #2;
        R_N = 1'b0;
        #1;
        check_exp("async_rst_now", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
        tick_i = 1'b1;
        @(posedge CLK1);
        #1;
        tick_i = 1'b0;
        check_exp("async_rst_held", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
        R_N = 1'b1;
        m_ph = 0; m_el = 0; m_to = 0;
        apply(NO);
        check_exp("async_after", 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] in;
            in[0] = ($urandom_range(0, 2) == 0);
            in[1] = ($urandom_range(0, 59) == 0);
            in[2] = ($urandom_range(0, 39) == 0);
            in[3] = ($urandom_range(0, 19) == 0);
            in[4] = ($urandom_range(0, 5) == 0);
            in[5] = ($urandom_range(0, 7) == 0);
            apply(in);
            check_model($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
